// File: rtl/pc_inc_adder.sv
`default_nettype none
// ============================================================================
// pc_inc_adder : IF-stage PC + INC with wrap/misalign flags, registered copy
//                and enabled-increment counter.
// Revision     : 1.0  initial release
// ============================================================================
module pc_inc_adder #(
  parameter int XLEN  = 32,
  parameter int INC   = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PC_out,
  input  logic             en,
  output logic [XLEN-1:0]  inc_pc,
  output logic             wrap,
  output logic             misaligned,
  output logic [XLEN-1:0]  inc_pc_q,
  output logic             inc_valid_q,
  output logic [CNT_W-1:0] inc_count
);

  localparam logic [XLEN:0]    C_INC_EXT = (XLEN+1)'(INC);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [XLEN:0]    w_sum;
  logic [XLEN-1:0]  inc_pc_d;
  logic             inc_valid_d;
  logic [CNT_W-1:0] inc_count_d;
  logic [CNT_W-1:0] inc_count_q;

  // Carry-out of the XLEN+1-bit unsigned add is the wrap flag.
  assign w_sum      = {1'b0, PC_out} + C_INC_EXT;
  assign inc_pc     = w_sum[XLEN-1:0];
  assign wrap       = w_sum[XLEN];
  assign misaligned = |PC_out[1:0];

  always_comb begin
    inc_pc_d    = inc_pc_q;
    inc_valid_d = en;
    inc_count_d = inc_count_q;
    if (en) begin
      inc_pc_d    = inc_pc;
      inc_count_d = inc_count_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_pc_q    <= '0;
      inc_valid_q <= 1'b0;
      inc_count_q <= '0;
    end else begin
      inc_pc_q    <= inc_pc_d;
      inc_valid_q <= inc_valid_d;
      inc_count_q <= inc_count_d;
    end
  end

  assign inc_count = inc_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_inc_adder.sv
`default_nettype none
// ============================================================================
// tb_pc_inc_adder : directed vectors plus random sweep for pc_inc_adder.
// Revision        : 1.0  initial release
// ============================================================================
module tb_pc_inc_adder;

  logic        clk;
  logic        rst;
  logic [31:0] PC_out;
  logic        en;
  logic [31:0] inc_pc;
  logic        wrap;
  logic        misaligned;
  logic [31:0] inc_pc_q;
  logic        inc_valid_q;
  logic [31:0] inc_count;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_inc_adder #(.XLEN(32), .INC(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_out      (PC_out),
    .en          (en),
    .inc_pc      (inc_pc),
    .wrap        (wrap),
    .misaligned  (misaligned),
    .inc_pc_q    (inc_pc_q),
    .inc_valid_q (inc_valid_q),
    .inc_count   (inc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r_pc;
    logic [32:0] r_exp;

    rst    = 1'b1;
    en     = 1'b0;
    PC_out = 32'd16;

    // Combinational result before any clock edge
    #1;
    check("basic_inc_pc", 64'(inc_pc), 64'd20);
    check("basic_wrap", 64'(wrap), 64'd0);
    check("basic_misaligned", 64'(misaligned), 64'd0);

    tick();
    tick();
    check("reset_inc_pc_q", 64'(inc_pc_q), 64'd0);
    check("reset_inc_valid_q", 64'(inc_valid_q), 64'd0);
    check("reset_inc_count", 64'(inc_count), 64'd0);
    check("reset_comb_unaffected", 64'(inc_pc), 64'd20);

    PC_out = 32'hFFFF_FFFC;
    #1;
    check("wrap_top_inc_pc", 64'(inc_pc), 64'h0000_0000);
    check("wrap_top_wrap", 64'(wrap), 64'd1);
    PC_out = 32'hFFFF_FFF8;
    #1;
    check("wrap_below_inc_pc", 64'(inc_pc), 64'hFFFF_FFFC);
    check("wrap_below_wrap", 64'(wrap), 64'd0);

    PC_out = 32'h0000_0006;
    #1;
    check("mis_inc_pc", 64'(inc_pc), 64'h0000_000A);
    check("mis_flag", 64'(misaligned), 64'd1);
    PC_out = 32'h0000_0100;
    #1;
    check("aligned_inc_pc", 64'(inc_pc), 64'h0000_0104);
    check("aligned_flag", 64'(misaligned), 64'd0);

    // Registered path
    rst    = 1'b0;
    PC_out = 32'd16;
    en     = 1'b1;
    tick();
    check("reg_e1_inc_pc_q", 64'(inc_pc_q), 64'd20);
    check("reg_e1_valid", 64'(inc_valid_q), 64'd1);
    check("reg_e1_count", 64'(inc_count), 64'd1);
    tick();
    tick();
    check("reg_e3_count", 64'(inc_count), 64'd3);
    check("reg_e3_inc_pc_q", 64'(inc_pc_q), 64'd20);

    en     = 1'b0;
    PC_out = 32'h0000_0080;
    tick();
    check("hold_valid", 64'(inc_valid_q), 64'd0);
    check("hold_inc_pc_q", 64'(inc_pc_q), 64'd20);
    check("hold_count", 64'(inc_count), 64'd3);

    // Reset mid-operation with en held high
    PC_out = 32'h0000_0040;
    en     = 1'b1;
    tick();
    tick();
    check("mid_pre_count", 64'(inc_count), 64'd5);
    check("mid_pre_inc_pc_q", 64'(inc_pc_q), 64'h44);
    rst = 1'b1;
    tick();
    check("mid_rst_inc_pc_q", 64'(inc_pc_q), 64'd0);
    check("mid_rst_valid", 64'(inc_valid_q), 64'd0);
    check("mid_rst_count", 64'(inc_count), 64'd0);
    check("mid_rst_inc_pc", 64'(inc_pc), 64'h44);
    rst = 1'b0;
    tick();
    check("mid_post_inc_pc_q", 64'(inc_pc_q), 64'h44);
    check("mid_post_count", 64'(inc_count), 64'd1);
    check("mid_post_valid", 64'(inc_valid_q), 64'd1);

    // Random sweep, with the boundary values seeded at the start
    en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)      r_pc = 32'hFFFF_FFFC;
      else if (i == 1) r_pc = 32'hFFFF_FFFF;
      else if (i == 2) r_pc = 32'hFFFF_FFFB;
      else             r_pc = $urandom;
      PC_out = r_pc;
      #1;
      r_exp = {1'b0, r_pc} + 33'd4;
      check("sweep_inc_pc", 64'(inc_pc), 64'(r_exp[31:0]));
      check("sweep_wrap", 64'(wrap), 64'(r_pc >= 32'hFFFF_FFFC));
      check("sweep_misaligned", 64'(misaligned), 64'(r_pc[1:0] != 2'b00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
